// File: rtl/fifo_fwft_reader.sv
// Read-domain dequeue adapter: pops the async FIFO and presents a first-word-fall-through
// valid/ready stream through a 2-entry head/skid buffer. FIFO_FWFT_LEVEL_EN adds a level port.
module fifo_fwft_reader #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_inc,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef FIFO_FWFT_LEVEL_EN
    output logic [1:0]            level,
`endif
    input  logic                  out_ready
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  inflight_q, inflight_d;
    logic                  out_valid_q, out_valid_d;
    logic                  pop;
    logic                  arrive;
    logic [1:0]            count_q, count_d;
    logic [2:0]            pending;

    always_comb begin
        count_q = 2'd0;
        unique case (state_q)
            StOne:   count_q = 2'd1;
            StTwo:   count_q = 2'd2;
            default: count_q = 2'd0;
        endcase
    end

    assign pop    = out_valid_q && out_ready;
    assign arrive = inflight_q;

    // Words already owned by the adapter after this cycle's pop; pop implies count >= 1.
    assign pending  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_inc = !reset && !fifo_empty && (pending < 3'd2);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (arrive) begin
                    head_d  = fifo_data;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (arrive && !pop) begin
                    skid_d  = fifo_data;
                    state_d = StTwo;
                end else if (arrive && pop) begin
                    head_d = fifo_data;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    head_d = skid_q;
                    if (arrive) begin
                        skid_d = fifo_data;
                    end else begin
                        state_d = StOne;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        count_d = 2'd0;
        unique case (state_d)
            StOne:   count_d = 2'd1;
            StTwo:   count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    assign inflight_d  = fifo_inc;
    assign out_valid_d = (state_d != StEmpty);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            head_q      <= '0;
            skid_q      <= '0;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = head_q;

`ifdef FIFO_FWFT_LEVEL_EN
    logic [1:0] level_q, level_d;

    assign level_d = count_d + {1'b0, inflight_d};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 2'd0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: doc/fifo_fwft_reader.md
Name: fifo_fwft_reader

Overview:
- Dequeue-side adapter for the async FIFO, clocked in the read domain.
- Drives the FIFO's read-side pointer/status counter: its increment input and its empty flag.
- Captures words from the FIFO RAM read port, which has 1-cycle read latency.
- Presents them downstream as a first-word-fall-through valid/ready stream.
- A 2-entry internal buffer sustains one word per cycle with fully registered out_valid/out_data.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word.

Ports:
- clock  input  1  read-domain clock.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  empty status from the dequeue-mode pointer/status counter.
- fifo_inc  output  1  increment request to the dequeue-mode pointer/status counter (one word popped).
- fifo_data  input  DATA_WIDTH  RAM read data; valid the cycle after a cycle with fifo_inc=1 and fifo_empty=0.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  DATA_WIDTH  head word.
- out_ready  input  1  consumer accepts the word when out_valid=1 in the same cycle.

Behaviour:
- Reset is asynchronous and active-high; its deassertion is synchronised externally to clock.
- Reset values: out_valid=0, out_data=0, fifo_inc=0, occupancy state EMPTY, inflight=0, skid register=0.
- State holds the buffered count: EMPTY, ONE, TWO.
  - ONE: head register valid.
  - TWO: head and skid registers valid.
- inflight: registered flag, set for exactly one cycle after an accepted read (fifo_inc && !fifo_empty).
- pop = out_valid && out_ready.
- Read issue rule: fifo_inc = !fifo_empty && (count + inflight - pop) < 2.
  - count is 0/1/2 for EMPTY/ONE/TWO.
  - fifo_inc is combinational from registers, fifo_empty and out_ready.
  - It never asserts while fifo_empty=1.
- Arrival: when inflight=1, fifo_data is captured this clock edge.
  - Goes to head if head is empty or being popped this cycle.
  - Otherwise goes to skid.
- Transitions (A = arrival, P = pop):
  - EMPTY: A -> ONE (head=fifo_data). P is impossible.
  - ONE: A & !P -> TWO (skid=fifo_data). A & P -> ONE (head=fifo_data). !A & P -> EMPTY. Otherwise hold.
  - TWO: P -> ONE (head=skid). A cannot occur in TWO without P (guaranteed by the issue rule). !P -> hold.
- out_valid = (state != EMPTY), registered.
- out_data = head register; stable while out_valid=1 && out_ready=0.
- Latency: word present and FIFO non-empty at cycle N -> fifo_inc at N -> out_valid at N+2.
- Throughput: 1 word/cycle with out_ready held high and the FIFO continuously non-empty.
- Order is preserved; no word is duplicated or dropped.
- Boundaries:
  - fifo_empty rising in the same cycle as a pop: no read issued, buffer drains normally.
  - fifo_empty=1 with inflight=1: the inflight word is still captured.
  - Reset mid-transfer discards the buffered and inflight words. FIFO pointers are reset by the same reset, so nothing is lost relative to the FIFO state.
  - out_ready=1 with out_valid=0: no effect.

Optional Feature:
- Macro: FIFO_FWFT_LEVEL_EN.
- Defined: adds output port level [1:0] = count + inflight, registered.
  - Reset value 0; range 0..2.
  - Updated every edge with the next count and next inflight.
- Undefined: port absent; core behaviour identical.

Test Plan:
- Reset check: assert reset mid-stream with 2 words buffered -> out_valid=0, fifo_inc=0, out_data=0 immediately, without waiting for a clock edge.
- Single word: FIFO holds 0xA5, out_ready=1 -> fifo_inc=1 at cycle 0, out_valid=1 with out_data=0xA5 at cycle 2, popped, out_valid=0 at cycle 3.
- Streaming: FIFO holds 0x01..0x10, out_ready=1 constantly -> 16 consecutive out_valid cycles, data 0x01..0x10 in order, no bubbles after the first word.
- Backpressure: FIFO holds 0x01..0x05, out_ready=0 -> exactly 2 fifo_inc pulses, state TWO, out_data=0x01 held. Then out_ready=1 -> 0x01..0x05 in order.
- Empty during stall: 1 word in FIFO, out_ready toggling 1/0 every cycle -> fifo_inc only while fifo_empty=0, single 0x5A delivered once.
- With FIFO_FWFT_LEVEL_EN: backpressure scenario -> level goes 0,1,2 and stays 2; after release, level stays in 1..2 and returns to 0 after the last pop.
